// File: rtl/stpmtr_phase_drv.sv
// Stepper coil phase driver: turns a step/direction stream into four coil phases,
// tracks absolute position, enforces step spacing and releases coils when idle.
// Define STPMTR_HALF_STEP_EN for the 8-entry half-step table (default: 4-entry full-step).
module stpmtr_phase_drv #(
    parameter int POS_W    = 16,
    parameter int MIN_GAP  = 4,
    parameter int HOLD_CYC = 1000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             pulse_i,
    input  logic             dir_i,
    output logic [3:0]       coil_o,
    output logic [POS_W-1:0] pos_o,
    output logic             busy_o,
    output logic             fault_o
);

`ifdef STPMTR_HALF_STEP_EN
    localparam int TBL_LEN = 8;
`else
    localparam int TBL_LEN = 4;
`endif
    localparam int IDX_W  = $clog2(TBL_LEN);
    localparam int GAP_W  = $clog2(MIN_GAP + 1);
    localparam int IDLE_W = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;

    // Last gap count before returning to HOLD; the GAP state lasts MIN_GAP-1 cycles.
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((MIN_GAP >= 2) ? (MIN_GAP - 2) : 0);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((HOLD_CYC > 0) ? (HOLD_CYC - 1) : 0);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = {IDLE_W{1'b1}};

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_GAP   = 2'd2,
        ST_RELAX = 2'd3
    } state_t;

    state_t            st_q,    st_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic [POS_W-1:0]  pos_q,   pos_d;
    logic [GAP_W-1:0]  gap_q,   gap_d;
    logic [IDLE_W-1:0] idle_q,  idle_d;
    logic [3:0]        coil_q,  coil_d;
    logic              fault_q, fault_d;
    logic              pulse_q;
    logic              step;
    logic              accept;

    function automatic logic [3:0] phase_tbl(input logic [IDX_W-1:0] idx);
        logic [3:0] ph;
`ifdef STPMTR_HALF_STEP_EN
        case (idx)
            3'd0:    ph = 4'b1000;
            3'd1:    ph = 4'b1100;
            3'd2:    ph = 4'b0100;
            3'd3:    ph = 4'b0110;
            3'd4:    ph = 4'b0010;
            3'd5:    ph = 4'b0011;
            3'd6:    ph = 4'b0001;
            default: ph = 4'b1001;
        endcase
`else
        case (idx)
            2'd0:    ph = 4'b1100;
            2'd1:    ph = 4'b0110;
            2'd2:    ph = 4'b0011;
            default: ph = 4'b1001;
        endcase
`endif
        return ph;
    endfunction

    // A level-high pulse produces exactly one step on its rising edge.
    assign step = pulse_i & ~pulse_q;

    always_comb begin
        st_d    = st_q;
        idx_d   = idx_q;
        pos_d   = pos_q;
        gap_d   = gap_q;
        idle_d  = idle_q;
        fault_d = fault_q;
        accept  = 1'b0;

        if (!en_i) begin
            st_d    = ST_OFF;
            gap_d   = '0;
            idle_d  = '0;
            fault_d = 1'b0;
        end else begin
            case (st_q)
                ST_OFF: begin
                    st_d = ST_HOLD;
                end
                ST_HOLD: begin
                    if (step) begin
                        accept = 1'b1;
                    end else if ((HOLD_CYC != 0) && (idle_q == IDLE_LAST)) begin
                        st_d   = ST_RELAX;
                        idle_d = '0;
                    end else if (idle_q != IDLE_MAX) begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
                end
                ST_GAP: begin
                    if (step) begin
                        fault_d = 1'b1;
                    end
                    if (gap_q == GAP_LAST) begin
                        st_d   = ST_HOLD;
                        gap_d  = '0;
                        idle_d = '0;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
                default: begin
                    if (step) begin
                        accept = 1'b1;
                    end
                end
            endcase

            if (accept) begin
                if (dir_i) begin
                    idx_d = idx_q + IDX_W'(1);
                    pos_d = pos_q + POS_W'(1);
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                    pos_d = pos_q - POS_W'(1);
                end
                gap_d  = '0;
                idle_d = '0;
                // With MIN_GAP of 1 the edge detector alone spaces steps, so no GAP state.
                st_d   = (MIN_GAP > 1) ? ST_GAP : ST_HOLD;
            end
        end

        coil_d = ((st_d == ST_HOLD) || (st_d == ST_GAP)) ? phase_tbl(idx_d) : 4'b0000;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st_q    <= ST_OFF;
            idx_q   <= '0;
            pos_q   <= '0;
            gap_q   <= '0;
            idle_q  <= '0;
            coil_q  <= 4'b0000;
            fault_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            st_q    <= st_d;
            idx_q   <= idx_d;
            pos_q   <= pos_d;
            gap_q   <= gap_d;
            idle_q  <= idle_d;
            coil_q  <= coil_d;
            fault_q <= fault_d;
            pulse_q <= pulse_i;
        end
    end

    assign coil_o  = coil_q;
    assign pos_o   = pos_q;
    assign busy_o  = (st_q == ST_GAP);
    assign fault_o = fault_q;

endmodule

// File: tb/tb_stpmtr_phase_drv.sv
// Bench for stpmtr_phase_drv: directed scenarios with literal expectations, then
// randomized pulse traffic checked every cycle against a deadline-based behavioural model.
module tb_stpmtr_phase_drv;

    localparam int POS_W    = 16;
    localparam int MIN_GAP  = 4;
    localparam int HOLD_CYC = 20;
`ifdef STPMTR_HALF_STEP_EN
    localparam int TL = 8;
`else
    localparam int TL = 4;
`endif

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             en_i = 1'b0;
    logic             pulse_i = 1'b0;
    logic             dir_i = 1'b1;
    logic [3:0]       coil_o;
    logic [POS_W-1:0] pos_o;
    logic             busy_o;
    logic             fault_o;

    int n_chk = 0;
    int n_err = 0;

    stpmtr_phase_drv #(
        .POS_W   (POS_W),
        .MIN_GAP (MIN_GAP),
        .HOLD_CYC(HOLD_CYC)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (en_i),
        .pulse_i(pulse_i),
        .dir_i  (dir_i),
        .coil_o (coil_o),
        .pos_o  (pos_o),
        .busy_o (busy_o),
        .fault_o(fault_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural model: position/phase as plain integers, coil release and step
    // spacing expressed as edge-count deadlines measured from the last event.
    logic [3:0]       m_tbl [TL];
    int               m_edge = 0;
    int               m_phase = 0;
    logic [POS_W-1:0] m_pos = '0;
    bit               m_active = 1'b0;
    bit               m_energ = 1'b0;
    bit               m_fault = 1'b0;
    bit               m_acc_valid = 1'b0;
    int               m_last_acc = 0;
    int               m_deadline = 0;
    bit               m_pprev = 1'b0;

    initial begin
`ifdef STPMTR_HALF_STEP_EN
        m_tbl[0] = 4'b1000; m_tbl[1] = 4'b1100; m_tbl[2] = 4'b0100; m_tbl[3] = 4'b0110;
        m_tbl[4] = 4'b0010; m_tbl[5] = 4'b0011; m_tbl[6] = 4'b0001; m_tbl[7] = 4'b1001;
`else
        m_tbl[0] = 4'b1100; m_tbl[1] = 4'b0110; m_tbl[2] = 4'b0011; m_tbl[3] = 4'b1001;
`endif
    end

    initial forever begin
        bit stp;
        @(posedge clk_i or posedge rst_i);
        if (rst_i) begin
            m_phase = 0; m_pos = '0; m_active = 0; m_energ = 0; m_fault = 0;
            m_acc_valid = 0; m_pprev = 0;
        end else begin
            m_edge++;
            stp = pulse_i && !m_pprev;
            m_pprev = pulse_i;
            if (!en_i) begin
                m_active = 0; m_energ = 0; m_fault = 0; m_acc_valid = 0;
            end else if (!m_active) begin
                m_active = 1; m_energ = 1; m_deadline = m_edge + HOLD_CYC;
            end else if (stp && m_acc_valid && (m_edge - m_last_acc < MIN_GAP)) begin
                m_fault = 1;
            end else if (stp) begin
                if (dir_i) begin
                    m_phase = (m_phase + 1) % TL;
                    m_pos = m_pos + 16'd1;
                end else begin
                    m_phase = (m_phase + TL - 1) % TL;
                    m_pos = m_pos - 16'd1;
                end
                m_acc_valid = 1; m_last_acc = m_edge; m_energ = 1;
                m_deadline = m_edge + MIN_GAP - 1 + HOLD_CYC;
            end else if (m_energ && (m_edge == m_deadline)) begin
                m_energ = 0;
            end
        end
    end

    initial forever begin
        logic [3:0] e_coil;
        bit         e_busy;
        @(negedge clk_i);
        e_coil = m_energ ? m_tbl[m_phase] : 4'b0000;
        e_busy = m_acc_valid && (m_edge - m_last_acc <= MIN_GAP - 2);
        n_chk++;
        if (coil_o !== e_coil || pos_o !== m_pos || busy_o !== e_busy || fault_o !== m_fault) begin
            n_err++;
            $display("FAIL model_cmp t=%0t coil=%b want %b pos=%h want %h busy=%b want %b fault=%b want %b",
                     $time, coil_o, e_coil, pos_o, m_pos, busy_o, e_busy, fault_o, m_fault);
        end
    end

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #2;
        end
    endtask

    task automatic pulse(input logic d);
        dir_i = d;
        pulse_i = 1'b1;
        cyc(1);
        pulse_i = 1'b0;
    endtask

    initial begin
        logic [3:0] walk [8];
        int pct;

        cyc(3);
        lit("reset_coil", 32'(coil_o), 32'h0);
        lit("reset_pos", 32'(pos_o), 32'h0);
        lit("reset_busy", 32'(busy_o), 32'h0);
        lit("reset_fault", 32'(fault_o), 32'h0);
        rst_i = 1'b0;
        cyc(1);
        en_i = 1'b1;
        cyc(1);

`ifdef STPMTR_HALF_STEP_EN
        lit("enable_coil", 32'(coil_o), 32'b1000);
        walk[0] = 4'b1100; walk[1] = 4'b0100; walk[2] = 4'b0110; walk[3] = 4'b0010;
        walk[4] = 4'b0011; walk[5] = 4'b0001; walk[6] = 4'b1001; walk[7] = 4'b1000;
        for (int i = 0; i < 8; i++) begin
            pulse(1'b1);
            lit($sformatf("half_walk%0d", i), 32'(coil_o), 32'(walk[i]));
            cyc(9);
        end
        lit("half_pos8", 32'(pos_o), 32'd8);
`else
        lit("enable_coil", 32'(coil_o), 32'b1100);
        lit("enable_pos", 32'(pos_o), 32'h0);
        lit("enable_fault", 32'(fault_o), 32'h0);
        walk[0] = 4'b0110; walk[1] = 4'b0011; walk[2] = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            pulse(1'b1);
            lit($sformatf("fwd_coil%0d", i), 32'(coil_o), 32'(walk[i]));
            cyc(9);
        end
        lit("fwd_pos3", 32'(pos_o), 32'd3);
        for (int i = 0; i < 4; i++) begin
            pulse(1'b0);
            cyc(9);
        end
        lit("rev_pos", 32'(pos_o), 32'hFFFF);
        lit("rev_coil", 32'(coil_o), 32'b1001);

        pulse(1'b1);
        lit("gap_busy", 32'(busy_o), 32'h1);
        cyc(1);
        pulse(1'b1);
        lit("gap_fault", 32'(fault_o), 32'h1);
        lit("gap_pos", 32'(pos_o), 32'h0);
        lit("gap_coil", 32'(coil_o), 32'b1100);
        cyc(10);
        lit("fault_sticky", 32'(fault_o), 32'h1);
        en_i = 1'b0;
        cyc(1);
        lit("dis_fault_clr", 32'(fault_o), 32'h0);
        lit("dis_coil", 32'(coil_o), 32'h0);
        en_i = 1'b1;
        cyc(1);

        cyc(19);
        lit("hold_still_on", 32'(coil_o), 32'b1100);
        cyc(1);
        lit("relax_coil", 32'(coil_o), 32'h0);
        pulse(1'b1);
        lit("relax_step_coil", 32'(coil_o), 32'b0110);
        lit("relax_step_pos", 32'(pos_o), 32'h1);
        cyc(3);

        en_i = 1'b0;
        pulse_i = 1'b1;
        cyc(1);
        lit("en_wins_coil", 32'(coil_o), 32'h0);
        lit("en_wins_pos", 32'(pos_o), 32'h1);
        cyc(3);
        en_i = 1'b1;
        cyc(46);
        lit("level_high_pos", 32'(pos_o), 32'h1);
        pulse_i = 1'b0;
        cyc(2);
        pulse(1'b1);
        lit("new_edge_pos", 32'(pos_o), 32'h2);
        lit("new_edge_coil", 32'(coil_o), 32'b0011);
        cyc(4);
`endif

        pulse_i = 1'b1;
        #1 rst_i = 1'b1;
        #1;
        lit("async_rst_coil", 32'(coil_o), 32'h0);
        lit("async_rst_pos", 32'(pos_o), 32'h0);
        lit("async_rst_fault", 32'(fault_o), 32'h0);
        cyc(2);
        rst_i = 1'b0;
        pulse_i = 1'b0;
        cyc(1);

        for (int seg = 0; seg < 4; seg++) begin
            pct = (seg == 0) ? 50 : (seg == 1) ? 20 : (seg == 2) ? 6 : 2;
            for (int c = 0; c < 600; c++) begin
                en_i    = ($urandom_range(0, 63) != 0);
                pulse_i = ($urandom_range(0, 99) < pct);
                dir_i   = ($urandom_range(0, 3) != 0);
                cyc(1);
            end
        end

        en_i = 1'b1;
        pulse_i = 1'b0;
        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
